// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, the mult/div
// FSM states and the register-match helper.
package hazard_ctrl_pkg;

   // Branch comparator operand sources
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Mult/div unit occupancy states
   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // A stage destination matches a source only if it writes and is not $0
   function automatic logic reg_match(input logic en, input logic [4:0] src,
                                      input logic [4:0] dst);
      return en && (src == dst) && (src != 5'd0);
   endfunction

endpackage

// File: rtl/md_timer.sv
// Mult/div busy timer: counts down MD_LATENCY cycles after an accepted issue.
module md_timer
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy
);

   localparam logic [5:0] LOAD = 6'(MD_LATENCY);

   md_state_t  state;
   logic [5:0] cnt;

   // FSM with registered busy; leaves MD_BUSY on the edge where cnt goes 1 -> 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MD_IDLE;
         cnt   <= 6'd0;
         busy  <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               // start is ignored while busy; the issuer is stalled until idle
               if (start) begin
                  state <= MD_BUSY;
                  cnt   <= LOAD;
                  busy  <= 1'b1;
               end
            end
            MD_BUSY: begin
               cnt <= cnt - 6'd1;
               if (cnt == 6'd1) begin
                  state <= MD_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= MD_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: stall/flush decisions,
// decode-stage comparator forwarding, mult/div busy tracking and event counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs_addr,
   input  logic [4:0]  id_rt_addr,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_branch,
   input  logic        id_taken,
   input  logic        id_md_start,
   input  logic        id_md_read,
   input  logic        ex_rd_en,
   input  logic        ex_mem_rd,
   input  logic [4:0]  ex_rd_addr,
   input  logic        mem_rd_en,
   input  logic        mem_mem_rd,
   input  logic [4:0]  mem_rd_addr,
   input  logic        wb_rd_en,
   input  logic [4:0]  wb_rd_addr,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic [1:0]  fwd_rs,
   output logic [1:0]  fwd_rt,
   output logic        md_busy,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);

   logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
   logic load_use, branch_alu, branch_load, md_hazard, stall;

   // Per-stage destination matches against both decode sources
   always_comb begin
      ex_rs  = reg_match(ex_rd_en,  id_rs_addr, ex_rd_addr);
      ex_rt  = reg_match(ex_rd_en,  id_rt_addr, ex_rd_addr);
      mem_rs = reg_match(mem_rd_en, id_rs_addr, mem_rd_addr);
      mem_rt = reg_match(mem_rd_en, id_rt_addr, mem_rd_addr);
      wb_rs  = reg_match(wb_rd_en,  id_rs_addr, wb_rd_addr);
      wb_rt  = reg_match(wb_rd_en,  id_rt_addr, wb_rd_addr);
   end

   // Stall terms; a load in EX ahead of a branch stalls once here and again in MEM
   always_comb begin
      load_use    = ex_mem_rd && ((id_uses_rs && ex_rs) || (id_uses_rt && ex_rt));
      branch_alu  = id_branch && !ex_mem_rd && (ex_rs || ex_rt);
      branch_load = id_branch && mem_mem_rd && (mem_rs || mem_rt);
      md_hazard   = (id_md_read || id_md_start) && md_busy;
      stall       = load_use || branch_alu || branch_load || md_hazard;
   end

   // Pipeline control; a stall freezes fetch and masks a taken branch
   always_comb begin
      pc_en        = !stall;
      if_id_en     = !stall;
      id_ex_bubble = stall;
      if_id_flush  = !stall && id_taken;
   end

   // Comparator forwarding; loads in MEM have no data yet, so they fall through
   always_comb begin
      fwd_rs = FWD_REG;
      fwd_rt = FWD_REG;
      if (mem_rs && !mem_mem_rd) begin
         fwd_rs = FWD_MEM;
      end else if (wb_rs) begin
         fwd_rs = FWD_WB;
      end
      if (mem_rt && !mem_mem_rd) begin
         fwd_rt = FWD_MEM;
      end else if (wb_rt) begin
         fwd_rt = FWD_WB;
      end
   end

   md_timer #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_timer (
      .clk   (clk),
      .rst   (rst),
      .start (id_md_start && !stall),
      .busy  (md_busy)
   );

   // Free-running event counters, wrapping modulo 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= 32'd0;
         flush_count <= 32'd0;
      end else begin
         if (stall) begin
            stall_count <= stall_count + 32'd1;
         end
         if (if_id_flush) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with a 4-cycle mult/div latency.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs_addr, id_rt_addr;
   logic        id_uses_rs, id_uses_rt, id_branch, id_taken, id_md_start, id_md_read;
   logic        ex_rd_en, ex_mem_rd;
   logic [4:0]  ex_rd_addr;
   logic        mem_rd_en, mem_mem_rd;
   logic [4:0]  mem_rd_addr;
   logic        wb_rd_en;
   logic [4:0]  wb_rd_addr;
   logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, md_busy;
   logic [1:0]  fwd_rs, fwd_rt;
   logic [31:0] stall_count, flush_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .MD_LATENCY (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs_addr   (id_rs_addr),
      .id_rt_addr   (id_rt_addr),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_branch    (id_branch),
      .id_taken     (id_taken),
      .id_md_start  (id_md_start),
      .id_md_read   (id_md_read),
      .ex_rd_en     (ex_rd_en),
      .ex_mem_rd    (ex_mem_rd),
      .ex_rd_addr   (ex_rd_addr),
      .mem_rd_en    (mem_rd_en),
      .mem_mem_rd   (mem_mem_rd),
      .mem_rd_addr  (mem_rd_addr),
      .wb_rd_en     (wb_rd_en),
      .wb_rd_addr   (wb_rd_addr),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .if_id_flush  (if_id_flush),
      .id_ex_bubble (id_ex_bubble),
      .fwd_rs       (fwd_rs),
      .fwd_rt       (fwd_rt),
      .md_busy      (md_busy),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear();
      id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_branch = 0; id_taken = 0; id_md_start = 0; id_md_read = 0;
      ex_rd_en = 0; ex_mem_rd = 0; ex_rd_addr = 0;
      mem_rd_en = 0; mem_mem_rd = 0; mem_rd_addr = 0;
      wb_rd_en = 0; wb_rd_addr = 0;
   endtask

   // Advance one clock; inputs are driven and outputs sampled mid-cycle
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_stalled(input string tag, input logic exp_stall);
      chk({tag, "_pc_en"}, {31'd0, pc_en}, {31'd0, !exp_stall});
      chk({tag, "_if_id_en"}, {31'd0, if_id_en}, {31'd0, !exp_stall});
      chk({tag, "_bubble"}, {31'd0, id_ex_bubble}, {31'd0, exp_stall});
   endtask

   initial begin
      clear();
      rst = 1'b1;
      #1;
      chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
      chk("rst_stall_count", stall_count, 32'd0);
      chk("rst_flush_count", flush_count, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Idle: everything flows
      chk_stalled("idle", 1'b0);
      chk("idle_flush", {31'd0, if_id_flush}, 32'd0);
      chk("idle_fwd", {28'd0, fwd_rs, fwd_rt}, 32'd0);

      // Load-use on rs
      ex_rd_en = 1; ex_mem_rd = 1; ex_rd_addr = 2; id_uses_rs = 1; id_rs_addr = 2;
      #1;
      chk_stalled("lu", 1'b1);
      chk("lu_flush", {31'd0, if_id_flush}, 32'd0);
      tick();
      chk("lu_stall_count", stall_count, 32'd1);
      clear();
      mem_rd_en = 1; mem_mem_rd = 1; mem_rd_addr = 2; id_uses_rs = 1; id_rs_addr = 2;
      #1;
      chk_stalled("lu_next", 1'b0);
      chk("lu_next_fwd_rs", {30'd0, fwd_rs}, 32'd0);
      tick();

      // Branch after ALU producer: one stall then MEM forward
      clear();
      id_branch = 1; id_uses_rs = 1; id_rs_addr = 3; ex_rd_en = 1; ex_rd_addr = 3;
      #1;
      chk_stalled("br_alu", 1'b1);
      tick();
      clear();
      id_branch = 1; id_uses_rs = 1; id_rs_addr = 3; mem_rd_en = 1; mem_rd_addr = 3;
      #1;
      chk_stalled("br_alu_next", 1'b0);
      chk("br_alu_fwd_rs", {30'd0, fwd_rs}, 32'd1);
      tick();
      chk("br_alu_stall_count", stall_count, 32'd2);

      // Branch after load: two stalls then WB forward
      clear();
      id_branch = 1; id_uses_rt = 1; id_rt_addr = 4;
      ex_rd_en = 1; ex_mem_rd = 1; ex_rd_addr = 4;
      #1;
      chk_stalled("br_ld_ex", 1'b1);
      tick();
      ex_rd_en = 0; ex_mem_rd = 0; ex_rd_addr = 0;
      mem_rd_en = 1; mem_mem_rd = 1; mem_rd_addr = 4;
      #1;
      chk_stalled("br_ld_mem", 1'b1);
      chk("br_ld_mem_fwd_rt", {30'd0, fwd_rt}, 32'd0);
      tick();
      mem_rd_en = 0; mem_mem_rd = 0; mem_rd_addr = 0;
      wb_rd_en = 1; wb_rd_addr = 4;
      #1;
      chk_stalled("br_ld_wb", 1'b0);
      chk("br_ld_fwd_rt", {30'd0, fwd_rt}, 32'd2);
      chk("br_ld_stall_count", stall_count, 32'd4);
      tick();

      // Taken branch flushes; taken plus load-use does not
      clear();
      id_taken = 1;
      #1;
      chk("taken_flush", {31'd0, if_id_flush}, 32'd1);
      chk_stalled("taken", 1'b0);
      tick();
      chk("taken_flush_count", flush_count, 32'd1);
      ex_rd_en = 1; ex_mem_rd = 1; ex_rd_addr = 2; id_uses_rs = 1; id_rs_addr = 2;
      #1;
      chk("taken_stall_flush", {31'd0, if_id_flush}, 32'd0);
      chk_stalled("taken_stall", 1'b1);
      tick();
      chk("taken_stall_flush_count", flush_count, 32'd1);
      chk("taken_stall_count", stall_count, 32'd5);

      // Register $0 never matches
      clear();
      ex_rd_en = 1; ex_mem_rd = 1; id_uses_rs = 1; id_uses_rt = 1; id_branch = 1;
      mem_rd_en = 1; wb_rd_en = 1;
      #1;
      chk_stalled("zero", 1'b0);
      chk("zero_fwd", {28'd0, fwd_rs, fwd_rt}, 32'd0);
      tick();

      // MEM beats WB; different per-operand sources
      clear();
      id_rs_addr = 5; id_rt_addr = 6;
      mem_rd_en = 1; mem_rd_addr = 5; wb_rd_en = 1; wb_rd_addr = 5;
      #1;
      chk("prio_fwd_rs", {30'd0, fwd_rs}, 32'd1);
      chk("prio_fwd_rt", {30'd0, fwd_rt}, 32'd0);
      wb_rd_addr = 6;
      #1;
      chk("split_fwd_rt", {30'd0, fwd_rt}, 32'd2);
      tick();

      // Mult/div: busy 4 cycles, mfhi stalled 4 cycles, released on the 5th
      clear();
      id_md_start = 1;
      #1;
      chk("md_issue_busy", {31'd0, md_busy}, 32'd0);
      chk_stalled("md_issue", 1'b0);
      tick();
      clear();
      id_md_read = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("md_busy_%0d", i), {31'd0, md_busy}, 32'd1);
         chk_stalled($sformatf("md_read_%0d", i), 1'b1);
         tick();
      end
      chk("md_done_busy", {31'd0, md_busy}, 32'd0);
      chk_stalled("md_release", 1'b0);
      chk("md_stall_count", stall_count, 32'd9);
      tick();

      // Start while busy waits and does not reload
      clear();
      id_md_start = 1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk_stalled($sformatf("md_restart_%0d", i), 1'b1);
         tick();
      end
      chk("md_restart_idle", {31'd0, md_busy}, 32'd0);
      chk_stalled("md_restart_issue", 1'b0);
      tick();
      clear();
      chk("md_rebusy", {31'd0, md_busy}, 32'd1);
      chk("md_restart_stall_count", stall_count, 32'd13);

      // Asynchronous reset mid-busy
      #1;
      rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, md_busy}, 32'd0);
      chk("arst_stall_count", stall_count, 32'd0);
      chk("arst_flush_count", flush_count, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_busy", {31'd0, md_busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
